// File: rtl/counter_bank_arbiter_if.sv
// Command/response bundle between the event requesters and the shared counter bank.
// Each requester owns one slice of the request vectors.
interface counter_bank_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 3,
   parameter int CNT_W   = 8,
   parameter int ID_W    = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]       req_valid;
   logic [2*NUM_REQ-1:0]     req_op;
   logic [IDX_W*NUM_REQ-1:0] req_idx;
   logic [NUM_REQ-1:0]       req_ready;
   logic                     rsp_valid;
   logic [ID_W-1:0]          rsp_id;
   logic [CNT_W-1:0]         rsp_data;
   logic                     rsp_ovf;

   modport master (
      output req_valid, req_op, req_idx,
      input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_ovf
   );

   modport slave (
      input  req_valid, req_op, req_idx,
      output req_ready, rsp_valid, rsp_id, rsp_data, rsp_ovf
   );
endinterface

// File: rtl/counter_bank_arbiter.sv
// Round-robin arbitrated counter bank: one INC/CLR/READ/NOP command per cycle,
// READ results returned one cycle later on a tagged response channel.
module counter_bank_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int NUM_CNT  = 8,
   parameter int IDX_W    = 3,
   parameter int CNT_W    = 8,
   parameter int SATURATE = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   counter_bank_arbiter_if.slave  bus
);
   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int SLOTS = 1 << IDX_W;

   // Opcode 2'b11 is NOP: it wins arbitration but matches none of these.
   localparam logic [1:0] OP_INC  = 2'b00;
   localparam logic [1:0] OP_CLR  = 2'b01;
   localparam logic [1:0] OP_READ = 2'b10;

   logic [PTR_W-1:0] ptr_reg;
   logic [PTR_W-1:0] ptr_next;
   logic [PTR_W-1:0] cand [NUM_REQ];
   logic             grant;
   logic [PTR_W-1:0] winner;
   logic [1:0]       win_op;
   logic [IDX_W-1:0] win_idx;

   logic [CNT_W-1:0] cnt_reg [SLOTS];
   logic             ovf_reg [SLOTS];
   logic [SLOTS-1:0] in_range;
   logic [SLOTS-1:0] slot_hit;

   logic             rsp_valid_reg;
   logic [PTR_W-1:0] rsp_id_reg;
   logic [CNT_W-1:0] rsp_data_reg;
   logic             rsp_ovf_reg;

   // Scan order: candidate k is requester (ptr + k) mod NUM_REQ.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
         logic [PTR_W:0] sum;
         assign sum      = {1'b0, ptr_reg} + (PTR_W+1)'(gi);
         assign cand[gi] = (sum >= (PTR_W+1)'(NUM_REQ)) ? PTR_W'(sum - (PTR_W+1)'(NUM_REQ))
                                                        : PTR_W'(sum);
      end
   endgenerate

   always_comb begin
      grant  = 1'b0;
      winner = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!grant && bus.req_valid[cand[k]]) begin
            grant  = 1'b1;
            winner = cand[k];
         end
      end
   end

   assign bus.req_ready = grant ? (NUM_REQ'(1) << winner) : '0;
   assign win_op        = bus.req_op[{winner, 1'b0} +: 2];
   assign win_idx       = bus.req_idx[int'(winner) * IDX_W +: IDX_W];

   always_comb begin
      ptr_next = ptr_reg;
      if (grant) begin
         ptr_next = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_reg <= '0;
      end else begin
         ptr_reg <= ptr_next;
      end
   end

   // Slots beyond NUM_CNT exist only so any index decodes; they never write and read as zero.
   generate
      for (gi = 0; gi < SLOTS; gi++) begin : g_slot
         assign in_range[gi] = (gi < NUM_CNT);
         assign slot_hit[gi] = grant && in_range[gi] && (win_idx == IDX_W'(gi));

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt_reg[gi] <= '0;
               ovf_reg[gi] <= 1'b0;
            end else if (slot_hit[gi]) begin
               if (win_op == OP_CLR) begin
                  cnt_reg[gi] <= '0;
                  ovf_reg[gi] <= 1'b0;
               end else if (win_op == OP_INC) begin
                  if (&cnt_reg[gi]) begin
                     ovf_reg[gi] <= 1'b1;
                     if (SATURATE == 0) begin
                        cnt_reg[gi] <= '0;
                     end
                  end else begin
                     cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
                  end
               end
            end
         end
      end
   endgenerate

   // Response captures pre-edge counter state; fields hold between pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_reg <= 1'b0;
         rsp_id_reg    <= '0;
         rsp_data_reg  <= '0;
         rsp_ovf_reg   <= 1'b0;
      end else begin
         rsp_valid_reg <= grant && (win_op == OP_READ);
         if (grant && (win_op == OP_READ)) begin
            rsp_id_reg   <= winner;
            rsp_data_reg <= cnt_reg[win_idx];
            rsp_ovf_reg  <= ovf_reg[win_idx];
         end
      end
   end

   assign bus.rsp_valid = rsp_valid_reg;
   assign bus.rsp_id    = rsp_id_reg;
   assign bus.rsp_data  = rsp_data_reg;
   assign bus.rsp_ovf   = rsp_ovf_reg;

endmodule

// File: tb/tb_counter_bank_arbiter.sv
// Directed bench for counter_bank_arbiter; a SATURATE=1 copy shares the same stimulus.
module tb_counter_bank_arbiter;
   localparam int NUM_REQ = 4;
   localparam int NUM_CNT = 8;
   localparam int IDX_W   = 3;
   localparam int CNT_W   = 8;

   localparam logic [1:0] INC  = 2'b00;
   localparam logic [1:0] CLR  = 2'b01;
   localparam logic [1:0] READ = 2'b10;
   localparam logic [1:0] NOP  = 2'b11;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   counter_bank_arbiter_if #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus0 ();
   counter_bank_arbiter_if #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus1 ();

   assign bus1.req_valid = bus0.req_valid;
   assign bus1.req_op    = bus0.req_op;
   assign bus1.req_idx   = bus0.req_idx;

   counter_bank_arbiter #(
      .NUM_REQ(NUM_REQ), .NUM_CNT(NUM_CNT), .IDX_W(IDX_W), .CNT_W(CNT_W), .SATURATE(0)
   ) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   counter_bank_arbiter #(
      .NUM_REQ(NUM_REQ), .NUM_CNT(NUM_CNT), .IDX_W(IDX_W), .CNT_W(CNT_W), .SATURATE(1)
   ) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_in();
      bus0.req_valid = '0;
      bus0.req_op    = '1;
      bus0.req_idx   = '0;
   endtask

   task automatic drive(input int r, input logic [1:0] op, input logic [IDX_W-1:0] idx);
      clear_in();
      bus0.req_valid[r]               = 1'b1;
      bus0.req_op[2*r +: 2]           = op;
      bus0.req_idx[IDX_W*r +: IDX_W]  = idx;
   endtask

   // Called at a falling edge; returns at the next falling edge after the grant edge.
   task automatic cmd(input string tag, input int r, input logic [1:0] op, input logic [IDX_W-1:0] idx);
      drive(r, op, idx);
      #1;
      chk({tag, " ready"}, 32'(bus0.req_ready), 32'(1 << r));
      @(negedge clk);
      clear_in();
      $display("[%0t] %s: req=%0d op=%0d idx=%0d rsp_valid=%0b id=%0d data=%0h ovf=%0b",
               $time, tag, r, op, idx, bus0.rsp_valid, bus0.rsp_id, bus0.rsp_data, bus0.rsp_ovf);
   endtask

   task automatic chk_rsp0(input string tag, input int id, input int data, input logic ovf);
      chk({tag, " valid"}, 32'(bus0.rsp_valid), 32'(1));
      chk({tag, " id"},    32'(bus0.rsp_id),    32'(id));
      chk({tag, " data"},  32'(bus0.rsp_data),  32'(data));
      chk({tag, " ovf"},   32'(bus0.rsp_ovf),   32'(ovf));
   endtask

   task automatic do_reset();
      clear_in();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      clear_in();
      @(negedge clk);
      do_reset();

      // Reset state
      chk("reset rsp_valid", 32'(bus0.rsp_valid), 0);
      chk("reset rsp_id",    32'(bus0.rsp_id),    0);
      chk("reset rsp_data",  32'(bus0.rsp_data),  0);
      chk("reset rsp_ovf",   32'(bus0.rsp_ovf),   0);
      #1;
      chk("idle ready", 32'(bus0.req_ready), 0);
      @(negedge clk);

      // READ of an untouched counter
      cmd("read5 r2", 2, READ, 3'd5);
      chk_rsp0("read5 rsp", 2, 8'h00, 1'b0);

      // Back-to-back INC then READ from one requester
      cmd("inc1 a", 0, INC, 3'd1);
      cmd("inc1 b", 0, INC, 3'd1);
      cmd("inc1 c", 0, INC, 3'd1);
      cmd("read1", 0, READ, 3'd1);
      chk_rsp0("read1 rsp", 0, 8'h03, 1'b0);
      @(negedge clk);
      chk("rsp pulse", 32'(bus0.rsp_valid), 0);
      chk("rsp hold data", 32'(bus0.rsp_data), 32'h03);

      // NOP consumes a grant but produces no response
      cmd("nop r1", 1, NOP, 3'd2);
      chk("nop no rsp", 32'(bus0.rsp_valid), 0);

      // Round-robin fairness from reset
      do_reset();
      bus0.req_valid = '1;
      for (int i = 0; i < NUM_REQ; i++) begin
         bus0.req_op[2*i +: 2]          = INC;
         bus0.req_idx[IDX_W*i +: IDX_W] = IDX_W'(i);
      end
      for (int c = 0; c < 8; c++) begin
         #1;
         chk("rr grant", 32'(bus0.req_ready), 32'(1 << (c % NUM_REQ)));
         $display("[%0t] rr cycle %0d ready=%b", $time, c, bus0.req_ready);
         @(negedge clk);
      end
      clear_in();
      for (int i = 0; i < NUM_REQ; i++) begin
         cmd("rr read", 0, READ, IDX_W'(i));
         chk_rsp0("rr rsp", 0, 8'h02, 1'b0);
      end

      // Overflow: 255 INC, boundary read, one more INC, CLR
      for (int n = 0; n < 255; n++) cmd("inc7", 0, INC, 3'd7);
      cmd("read7 ff", 0, READ, 3'd7);
      chk_rsp0("read7 ff rsp", 0, 8'hFF, 1'b0);
      chk("sat read7 ff data", 32'(bus1.rsp_data), 32'hFF);
      chk("sat read7 ff ovf",  32'(bus1.rsp_ovf),  0);
      cmd("inc7 wrap", 0, INC, 3'd7);
      cmd("read7 wrap", 0, READ, 3'd7);
      chk_rsp0("read7 wrap rsp", 0, 8'h00, 1'b1);
      chk("sat read7 data", 32'(bus1.rsp_data), 32'hFF);
      chk("sat read7 ovf",  32'(bus1.rsp_ovf),  1);
      cmd("clr7", 0, CLR, 3'd7);
      cmd("read7 clr", 0, READ, 3'd7);
      chk_rsp0("read7 clr rsp", 0, 8'h00, 1'b0);
      chk("sat clr data", 32'(bus1.rsp_data), 0);
      chk("sat clr ovf",  32'(bus1.rsp_ovf),  0);

      // Ordering: READ the cycle after an INC sees the new value
      cmd("inc4 r1", 1, INC, 3'd4);
      cmd("read4 r3", 3, READ, 3'd4);
      chk_rsp0("order rsp", 3, 8'h01, 1'b0);

      // Reset right after a READ grant drops its response
      drive(1, READ, 3'd4);
      #1;
      chk("midrst ready", 32'(bus0.req_ready), 32'b0010);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      clear_in();
      @(negedge clk);
      chk("midrst rsp_valid", 32'(bus0.rsp_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      chk("postrst rsp_valid", 32'(bus0.rsp_valid), 0);
      bus0.req_valid = '1;
      #1;
      chk("postrst first grant", 32'(bus0.req_ready), 32'b0001);
      @(negedge clk);
      clear_in();
      cmd("postrst read4", 2, READ, 3'd4);
      chk_rsp0("postrst read4 rsp", 2, 8'h00, 1'b0);
      cmd("postrst read1", 0, READ, 3'd1);
      chk_rsp0("postrst read1 rsp", 0, 8'h00, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/counter_bank_arbiter.md
Name: counter_bank_arbiter

Overview:
- Shares one bank of NUM_CNT event counters among NUM_REQ independent requesters.
- Each requester issues INC, CLR or READ commands against a counter index through a valid/ready handshake.
- A round-robin arbiter grants at most one command per cycle. READ results return on a single tagged response channel.
- Sits between the per-engine event sources and the status/readback logic; it is the only writer of the counter bank.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- NUM_CNT, 8, number of counters in the bank.
- IDX_W, 3, counter index width, equal to clog2(NUM_CNT).
- CNT_W, 8, counter width in bits.
- SATURATE, 0, selects overflow handling: 0 = wrap modulo 2^CNT_W, 1 = hold at all-ones.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester command valid.
- req_op  input  2*NUM_REQ  per-requester opcode, slice i = bits [2i+1:2i]: 00 INC, 01 CLR, 10 READ, 11 NOP.
- req_idx  input  IDX_W*NUM_REQ  per-requester counter index, slice i = bits [IDX_W*i+IDX_W-1:IDX_W*i].
- req_ready  output  NUM_REQ  one-hot grant; a command transfers when req_valid[i] and req_ready[i] are both high.
- rsp_valid  output  1  READ response valid, one-cycle pulse.
- rsp_id  output  clog2(NUM_REQ)  requester that issued the READ.
- rsp_data  output  CNT_W  counter value.
- rsp_ovf  output  1  sticky overflow flag of the counter read.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All counters and sticky ovf flags go to 0.
  - The round-robin pointer goes to 0.
  - rsp_valid, rsp_id, rsp_data and rsp_ovf go to 0.
  - Reset mid-operation discards any command in flight; no response is produced for it.
- Arbitration:
  - Combinational from req_valid and the pointer.
  - The winner is the first i with req_valid[i] high, scanning from pointer upward and wrapping.
  - req_ready is the one-hot winner, or all zeros when no requester is valid.
  - req_ready[i] never asserts while req_valid[i] is low. Requesters must hold valid/op/idx stable until accepted.
  - On a transfer, the pointer becomes winner+1 modulo NUM_REQ. With no transfer, the pointer holds.
  - Starvation bound: a continuously valid requester is granted within NUM_REQ cycles.
- INC: counter[idx] is updated at the grant edge.
  - SATURATE=0: counter <= counter+1. On wrap from all-ones to 0, ovf[idx] is set to 1.
  - SATURATE=1: an all-ones counter stays all-ones and ovf[idx] is set to 1.
- CLR: counter[idx] and ovf[idx] are set to 0 at the grant edge.
- READ:
  - Latency is 1 cycle. rsp_valid=1 on the cycle after the grant.
  - rsp_id = winner; rsp_data/rsp_ovf = the values of counter[idx] and ovf[idx] at the grant cycle, before the edge.
  - READ does not modify any state.
  - At most one response per cycle, and the response channel has no backpressure.
  - rsp_data/rsp_id/rsp_ovf hold their last values when rsp_valid=0.
- NOP: accepted and consumes the grant; no state change, no response.
- Ordering: commands take effect in grant order. A READ granted the cycle after an INC to the same index returns the incremented value.
- Index out of range (idx >= NUM_CNT): the command is accepted with no state change. A READ returns rsp_data=0 and rsp_ovf=0.
- Only one command executes per cycle, so no same-counter write conflicts exist.

Test Plan:
- Reset then READ idx 5 from req 2 → req_ready=0100 same cycle; next cycle rsp_valid=1, rsp_id=2, rsp_data=0x00, rsp_ovf=0.
- Req 0 issues 3 back-to-back INC to idx 1, then READ → rsp_data=0x03. Requests are accepted on consecutive cycles with no bubbles.
- All 4 requesters continuously valid with INC to idx 0..3 respectively, for 8 cycles from reset:
  - grant order is 0,1,2,3,0,1,2,3;
  - each counter then reads 0x02.
- SATURATE=0: 256 INC to idx 7 then READ → rsp_data=0x00, rsp_ovf=1. A following CLR idx 7, then READ → 0x00, ovf 0. With SATURATE=1 the first READ returns 0xFF, ovf 1.
- Req 1 INC idx 4 granted in cycle t, req 3 READ idx 4 granted in cycle t+1 → the response in cycle t+2 is 0x01 with rsp_id=3.
- Assert rst_n low mid-stream, one cycle after a READ grant → rsp_valid stays 0, counters read back 0 after release, and the first grant goes to req 0 when all requesters are valid.
